// File: rtl/irq_priority_resolver.sv
// irq_priority_resolver
//   Interrupt request / in-service / priority stage of an 8259A-style controller.
//   Holds IRR and ISR, resolves the highest-priority unmasked request against the
//   current in-service level with a rotatable lowest-priority pointer, and tracks
//   the two-pulse INTA acknowledge sequence.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   init              synchronous clear, same effect as reset
//   ir_in             raw IR0..IR7 request lines (synchronous to clk)
//   ltim              1 = level triggered, 0 = edge triggered
//   imr               interrupt mask (masked lines still latch into IRR)
//   inta_n            interrupt acknowledge, active low
//   eoi, aeoi, rotate end-of-interrupt pulse, auto-EOI mode, rotate-on-EOI
//   int_request       unmasked request outranks current in-service level
//   interrupt_number  resolved IR index, frozen during acknowledge
//   irr, isr          request and in-service registers
//   inta_count        0 idle, 1 after first INTA, 2 after second INTA
module irq_priority_resolver #(
   parameter int unsigned NUM_IR   = 8,
   parameter int unsigned RESET_LP = 7
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       init,
   input  logic [NUM_IR-1:0]          ir_in,
   input  logic                       ltim,
   input  logic [NUM_IR-1:0]          imr,
   input  logic                       inta_n,
   input  logic                       eoi,
   input  logic                       aeoi,
   input  logic                       rotate,
   output logic                       int_request,
   output logic [$clog2(NUM_IR)-1:0]  interrupt_number,
   output logic [NUM_IR-1:0]          irr,
   output logic [NUM_IR-1:0]          isr,
   output logic [1:0]                 inta_count
);

   localparam int unsigned IdxW = $clog2(NUM_IR);

   typedef enum logic [1:0] {StIdle = 2'd0, StAck1 = 2'd1, StAck2 = 2'd2} state_e;

   state_e            state_q, state_d;
   logic [NUM_IR-1:0] irr_q, irr_d, isr_q, isr_d, ir_prev_q, ir_prev_d;
   logic [IdxW-1:0]   lp_q, lp_d, num_q, num_d;
   logic              req_q, req_d, inta_prev_q, inta_prev_d;

   logic [IdxW:0]     cand, svc;
   logic              cand_valid, svc_valid, cand_outranks;
   logic [IdxW-1:0]   cand_idx, svc_idx;
   logic              inta_fall, inta_rise;

   // Returns {valid, index} of the highest-priority set bit; priority runs lp+1 .. lp.
   function automatic logic [IdxW:0] find_hi(input logic [NUM_IR-1:0] req,
                                             input logic [IdxW-1:0]   lp);
      logic [IdxW-1:0] idx;
      find_hi = '0;
      // Walk from lowest to highest priority so the highest one found wins.
      for (int i = NUM_IR; i >= 1; i--) begin
         idx = lp + IdxW'(i);
         if (req[idx]) find_hi = {1'b1, idx};
      end
   endfunction

   // Rank 0 is the highest priority level for the given lp.
   function automatic logic [IdxW-1:0] rank(input logic [IdxW-1:0] idx,
                                            input logic [IdxW-1:0] lp);
      rank = idx - lp - IdxW'(1);
   endfunction

   always_comb begin
      cand          = find_hi(irr_q & ~imr, lp_q);
      svc           = find_hi(isr_q, lp_q);
      cand_valid    = cand[IdxW];
      cand_idx      = cand[IdxW-1:0];
      svc_valid     = svc[IdxW];
      svc_idx       = svc[IdxW-1:0];
      cand_outranks = rank(cand_idx, lp_q) < rank(svc_idx, lp_q);
      inta_fall     = inta_prev_q & ~inta_n;
      inta_rise     = ~inta_prev_q & inta_n;
   end

   always_comb begin
      state_d     = state_q;
      isr_d       = isr_q;
      lp_d        = lp_q;
      num_d       = num_q;
      ir_prev_d   = ir_in;
      inta_prev_d = inta_n;
      if (ltim) begin
         irr_d = ir_in;
      end else begin
         // Edge mode: set on rising edge, dropped if the line falls before acceptance.
         irr_d = (irr_q & ir_in) | (ir_in & ~ir_prev_q);
      end

      // EOI clears against the ISR as it was before this edge.
      if (eoi && svc_valid) begin
         isr_d[svc_idx] = 1'b0;
         if (rotate) lp_d = svc_idx;
      end

      unique case (state_q)
         StIdle: begin
            if (inta_fall) begin
               state_d = StAck1;
               if (cand_valid) begin
                  isr_d[cand_idx] = 1'b1;
                  irr_d[cand_idx] = 1'b0;
                  num_d           = cand_idx;
               end else begin
                  num_d = '1;  // spurious acknowledge
               end
            end else if (cand_valid) begin
               num_d = cand_idx;
            end
         end
         StAck1: begin
            if (inta_fall) state_d = StAck2;
         end
         StAck2: begin
            if (inta_rise) begin
               state_d = StIdle;
               if (aeoi) begin
                  isr_d[num_q] = 1'b0;
                  if (rotate) lp_d = num_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      req_d = (state_d == StIdle) && cand_valid && ((isr_q == '0) || cand_outranks);

      if (init) begin
         state_d     = StIdle;
         irr_d       = '0;
         isr_d       = '0;
         lp_d        = IdxW'(RESET_LP);
         num_d       = '0;
         req_d       = 1'b0;
         ir_prev_d   = '0;
         inta_prev_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         irr_q       <= '0;
         isr_q       <= '0;
         lp_q        <= IdxW'(RESET_LP);
         num_q       <= '0;
         req_q       <= 1'b0;
         ir_prev_q   <= '0;
         inta_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         lp_q        <= lp_d;
         num_q       <= num_d;
         req_q       <= req_d;
         ir_prev_q   <= ir_prev_d;
         inta_prev_q <= inta_prev_d;
      end
   end

   assign int_request      = req_q;
   assign interrupt_number = num_q;
   assign irr              = irr_q;
   assign isr              = isr_q;
   assign inta_count       = state_q;

endmodule
